// File: rtl/zuart_tx_drain_if.sv
// FIFO read-port bundle between the byte FIFO and the UART transmit drain.
// The drain is the master: it issues the read strobe and consumes empty/data.
`timescale 1ns/1ps
interface zuart_tx_drain_if;
  logic       iEmpty;
  logic       oRdEn;
  logic [7:0] iData;

  modport master (input iEmpty, input iData, output oRdEn);
  modport slave  (output iEmpty, output iData, input oRdEn);
endinterface

// File: rtl/zuart_tx_drain.sv
// UART transmit drain: pops one byte from the FIFO per frame and shifts it
// out as 8N1/8N2, LSB first. FIFO read data is captured one cycle after the
// single-cycle read strobe.
`timescale 1ns/1ps
module zuart_tx_drain #(
  parameter int clks_per_bit = 104,
  parameter int log2_cpb     = 7,
  parameter int stop_bits    = 1
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iEn,
  zuart_tx_drain_if.master fifo,
  output logic             oTxd,
  output logic             oBusy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  localparam logic [log2_cpb-1:0] CNT_LAST  = log2_cpb'(clks_per_bit - 1);
  localparam logic [2:0]          STOP_LAST = 3'(stop_bits - 1);

  state_t              state_q, state_d;
  logic                rd_en_q, rd_en_d;
  logic                txd_q,   txd_d;
  logic                busy_q,  busy_d;
  logic [2:0]          bit_q,   bit_d;   // data bit index, reused as stop-bit index
  logic [log2_cpb-1:0] cnt_q,   cnt_d;
  logic [7:0]          shift_q, shift_d;

  logic                cnt_last;
  assign cnt_last = (cnt_q == CNT_LAST);

  // Register bank with synchronous active-low reset; line returns high at once.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_q <= IDLE;
      rd_en_q <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      bit_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // Next-state and registered-output logic; every output is set one edge ahead
  // so the pins change exactly with the state they belong to.
  always_comb begin
    state_d = state_q;
    rd_en_d = rd_en_q;
    txd_d   = txd_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;

    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        // The strobe is only ever raised here, so it can never hit an empty FIFO.
        if (iEn && !fifo.iEmpty) begin
          state_d = READ;
          rd_en_d = 1'b1;
        end
      end
      READ: begin
        rd_en_d = 1'b0;
        state_d = LOAD;
      end
      LOAD: begin
        // FIFO data is valid the cycle after the strobe.
        shift_d = fifo.iData;
        txd_d   = 1'b0;
        cnt_d   = '0;
        state_d = START;
      end
      START: begin
        if (cnt_last) begin
          cnt_d   = '0;
          bit_d   = '0;
          txd_d   = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + log2_cpb'(1);
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            txd_d   = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + log2_cpb'(1);
        end
      end
      STOP: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + log2_cpb'(1);
        end
      end
      default: begin
        state_d = IDLE;
        rd_en_d = 1'b0;
        txd_d   = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign fifo.oRdEn = rd_en_q;
  assign oTxd       = txd_q;
  assign oBusy      = busy_q;

endmodule

// File: tb/tb_zuart_tx_drain.sv
// Bench for zuart_tx_drain: a FIFO model feeds bytes, stimulus pushes the
// expected byte into a scoreboard queue, and a line receiver pops and checks
// every frame it sees. Directed timing checks run in the stimulus process.
`timescale 1ns/1ps
module tb_zuart_tx_drain;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n, en, txd, busy;
  logic en2, txd2, busy2;

  always #5 clk = ~clk;

  zuart_tx_drain_if fif();
  zuart_tx_drain_if fif2();

  zuart_tx_drain #(.clks_per_bit(CPB), .log2_cpb(2), .stop_bits(1)) u_dut (
    .iClk(clk), .iRstN(rst_n), .iEn(en), .fifo(fif), .oTxd(txd), .oBusy(busy));

  zuart_tx_drain #(.clks_per_bit(CPB), .log2_cpb(2), .stop_bits(2)) u_dut2 (
    .iClk(clk), .iRstN(rst_n), .iEn(en2), .fifo(fif2), .oTxd(txd2), .oBusy(busy2));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int busy_tot = 0;
  int hi_run = 0;
  int last_gap = 0;
  int underflow = 0;
  logic [7:0] fq[$];      // FIFO contents
  logic [7:0] exp_q[$];   // scoreboard: bytes expected on the line, in order
  int         rd_t[$];    // cycle stamps of read strobes

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!(fq.size() == 0 && busy === 1'b0) && n < limit) begin tick(1); n++; end
    check("drain timeout", 32'(n < limit), 1);
  endtask

  task automatic wait_txd_low(input int limit);
    int n = 0;
    while (txd !== 1'b0 && n < limit) begin tick(1); n++; end
    check("start bit timeout", 32'(n < limit), 1);
  endtask

  always @(posedge clk) cyc++;

  // FIFO model: pops on the strobe, data presented before the capture edge.
  always @(negedge clk) begin
    if (fif.oRdEn === 1'b1) begin
      if (fq.size() > 0) fif.iData = fq.pop_front();
      else underflow++;
    end
    fif.iEmpty = (fq.size() == 0);
  end

  // Passive observers: strobe times, busy cycles, high-run before each start bit.
  always @(negedge clk) begin
    if (fif.oRdEn === 1'b1) rd_t.push_back(cyc);
    if (busy === 1'b1) busy_tot++;
    if (txd === 1'b1) hi_run++;
    else begin
      if (hi_run > 0) last_gap = hi_run;
      hi_run = 0;
    end
  end

  // Line receiver / scoreboard checker: checks every cycle of each frame.
  initial begin : rx
    logic [7:0] want, got;
    int bad, idx;
    bit abort;
    logic lvl;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd === 1'b0) begin
        want  = (exp_q.size() > 0) ? exp_q[0] : 8'hxx;
        got   = '0;
        bad   = 0;
        abort = 1'b0;
        for (int c = 0; c < 10*CPB; c++) begin
          if (c > 0) @(negedge clk);
          if (rst_n !== 1'b1) begin abort = 1'b1; break; end
          idx = c / CPB;
          if (idx == 0)      lvl = 1'b0;
          else if (idx <= 8) lvl = want[idx-1];
          else               lvl = 1'b1;
          if (txd !== lvl) bad++;
          if (idx >= 1 && idx <= 8 && (c % CPB) == CPB/2) got[idx-1] = txd;
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (!abort) begin
          check("rx byte", 32'(got), 32'(want));
          check("rx frame shape", 32'(bad), 0);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int rd0, b0, t0, n, hi, bad2;
    int rd2[$];
    logic w2[0:63];
    logic [7:0] b2;
    logic lvl;

    rst_n = 1'b0; en = 1'b1; en2 = 1'b0;
    fif2.iEmpty = 1'b1; fif2.iData = 8'h00;

    // Reset held 3 cycles with data waiting.
    push(8'h11);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("reset txd", 32'(txd), 1);
      check("reset rd_en", 32'(fif.oRdEn), 0);
      check("reset busy", 32'(busy), 0);
    end
    rst_n = 1'b1;
    t0 = cyc;                      // first cycle after release (IDLE)
    rd0 = rd_t.size();
    wait_done(200);
    check("first strobe after reset", 32'(rd_t[rd0] - t0), 1);

    // Single byte 0xA5: one strobe, busy for READ+LOAD+10 bit periods = 42.
    rd0 = rd_t.size(); b0 = busy_tot;
    push(8'hA5);
    wait_done(200);
    check("A5 strobe count", 32'(rd_t.size() - rd0), 1);
    check("A5 busy cycles", 32'(busy_tot - b0), 42);

    // Back-to-back 0x00, 0xFF: strobes one frame + 3 cycles apart.
    rd0 = rd_t.size();
    push(8'h00); push(8'hFF);
    wait_done(300);
    check("b2b strobe count", 32'(rd_t.size() - rd0), 2);
    check("b2b strobe spacing", 32'(rd_t[rd0+1] - rd_t[rd0]), 10*CPB + 3);
    check("b2b line gap", 32'(last_gap), CPB + 3);

    // Enable dropped during first data bit with 3 bytes queued.
    rd0 = rd_t.size();
    push(8'h5A); push(8'hC3); push(8'h81);
    wait_txd_low(20);
    tick(CPB);
    en = 1'b0;
    tick(60);
    check("en-off strobe count", 32'(rd_t.size() - rd0), 1);
    check("en-off busy", 32'(busy), 0);
    check("en-off fifo level", 32'(fq.size()), 2);
    en = 1'b1;
    t0 = cyc;
    n = 0;
    while (rd_t.size() == rd0 + 1 && n < 10) begin tick(1); n++; end
    check("en-on strobe timeout", 32'(n < 10), 1);
    if (rd_t.size() > rd0 + 1) check("en-on strobe delay", 32'(rd_t[rd0+1] - t0), 1);
    wait_done(300);

    // Reset at data bit 3: in-flight byte dropped, next byte sent intact.
    rd0 = rd_t.size();
    push(8'h96); push(8'h3B);
    wait_txd_low(20);
    tick(4*CPB);
    rst_n = 1'b0;
    tick(1);
    check("mid reset txd", 32'(txd), 1);
    check("mid reset busy", 32'(busy), 0);
    check("mid reset rd_en", 32'(fif.oRdEn), 0);
    rst_n = 1'b1;
    wait_done(200);
    check("mid reset strobe count", 32'(rd_t.size() - rd0), 2);

    // Two stop bits, byte 0x3C, FIFO never empty; cycle 0 is this cycle.
    b2 = 8'h3C;
    fif2.iData = b2; fif2.iEmpty = 1'b0; en2 = 1'b1;
    for (int c = 1; c < 64; c++) begin
      tick(1);
      w2[c] = txd2;
      if (fif2.oRdEn === 1'b1) begin
        rd2.push_back(c);
        if (rd2.size() == 2) en2 = 1'b0;
      end
    end
    check("sb2 strobe count", 32'(rd2.size()), 2);
    if (rd2.size() == 2) begin
      check("sb2 first strobe", 32'(rd2[0]), 1);
      check("sb2 second strobe", 32'(rd2[1]), 3 + 11*CPB + 1);
    end
    bad2 = 0;
    for (int c = 3; c < 3 + 11*CPB; c++) begin
      n = (c - 3) / CPB;
      if (n == 0)      lvl = 1'b0;
      else if (n <= 8) lvl = b2[n-1];
      else             lvl = 1'b1;
      if (w2[c] !== lvl) bad2++;
    end
    check("sb2 frame shape", 32'(bad2), 0);
    hi = 0;
    for (int c = 3 + 9*CPB; c < 64 && w2[c] === 1'b1; c++) hi++;
    check("sb2 high run", 32'(hi), 2*CPB + 3);
    check("sb2 next start", 32'(w2[3 + 11*CPB + 3]), 0);

    check("scoreboard drained", 32'(exp_q.size()), 0);
    check("fifo underflow", 32'(underflow), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
